// File: rtl/mic1_pkg.sv
// Shared definitions for the MIC-1 microprogram sequencer.
// Holds the MIR field bit positions, the default halt address, the shift_ctrl
// encodings, the sequencer state enum and a reference shifter helper that
// applies a shift_ctrl code to a 32-bit datapath word.
package mic1_pkg;

  // MIR field positions (36-bit microinstruction)
  localparam int unsigned NEXT_HI  = 35;
  localparam int unsigned NEXT_LO  = 27;
  localparam int unsigned JMPC_BIT = 26;
  localparam int unsigned JAMN_BIT = 25;
  localparam int unsigned JAMZ_BIT = 24;
  localparam int unsigned SHIFT_HI = 23;
  localparam int unsigned SHIFT_LO = 22;
  localparam int unsigned ALU_HI   = 21;
  localparam int unsigned ALU_LO   = 16;
  localparam int unsigned CEN_HI   = 15;
  localparam int unsigned CEN_LO   = 7;
  localparam int unsigned MEM_HI   = 6;
  localparam int unsigned MEM_LO   = 4;
  localparam int unsigned BSEL_HI  = 3;
  localparam int unsigned BSEL_LO  = 0;

  localparam logic [8:0] HALT_ADDR = 9'h1FF;

  // shift_ctrl = {SLL8, SRA1}; 2'b11 falls through to bypass
  localparam logic [1:0] SHIFT_NONE = 2'b00;
  localparam logic [1:0] SHIFT_SRA1 = 2'b01;
  localparam logic [1:0] SHIFT_SLL8 = 2'b10;

  typedef enum logic [1:0] {
    StFetch,
    StRun,
    StStall,
    StHalt
  } seq_state_e;

  // Datapath shifter behaviour selected by shift_ctrl.
  function automatic logic [31:0] shift_apply(input logic [1:0]  ctrl,
                                              input logic [31:0] data);
    logic [31:0] res;
    case (ctrl)
      SHIFT_SRA1: res = {data[31], data[31:1]};
      SHIFT_SLL8: res = {data[23:0], 8'h00};
      default:    res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mic1_next_addr.sv
// Combinational next-microaddress logic for the MIC-1 sequencer.
// Ports:
//   next_address  in  9  NEXT_ADDRESS field of the MIR
//   jmpc, jamn, jamz in 1 jump control bits of the MIR
//   alu_n, alu_z  in  1  ALU flags of the current microinstruction
//   mbr           in  8  MBR contents, ORed into the low byte on JMPC
//   next_mpc      out 9  selected next microaddress
module mic1_next_addr
  import mic1_pkg::*;
(
  input  logic [8:0] next_address,
  input  logic       jmpc,
  input  logic       jamn,
  input  logic       jamz,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic [7:0] mbr,
  output logic [8:0] next_mpc
);

  logic       hi;
  logic [7:0] lo;

  always_comb begin
    hi       = next_address[8] | (jamz & alu_z) | (jamn & alu_n);
    // The OR stays inside 8 bits, so JMPC never disturbs the high bit.
    lo       = next_address[7:0] | (jmpc ? mbr : 8'h00);
    next_mpc = {hi, lo};
  end

endmodule

// File: rtl/mic1_sequencer.sv
// MIC-1 microprogram sequencer: holds MPC and MIR, addresses the external
// combinational control store and drives the datapath control fields.
// Adds a memory wait handshake (STALL) and a terminal HALT state.
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   rom_addr  out 9      control-store address (next_mpc, combinational)
//   rom_data  in  36     control-store word at rom_addr
//   alu_n, alu_z in 1    ALU flags for the current microinstruction
//   mbr       in  8      MBR contents for JMPC
//   wait_req  in  1      memory not ready; freeze sequencing
//   mpc       out 9      current microinstruction address
//   shift_ctrl/alu_ctrl/c_enable/mem_ctrl/b_sel out  MIR control fields
//   n_flag, z_flag out 1 latched N/Z of the last executed microinstruction
//   halted    out 1      sequencer is in HALT
module mic1_sequencer
  import mic1_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 9,
  parameter int unsigned       WORD_W    = 36,
  parameter logic [ADDR_W-1:0] HALT_ADDR = mic1_pkg::HALT_ADDR
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic [7:0]        mbr,
  input  logic              wait_req,
  output logic [ADDR_W-1:0] mpc,
  output logic [1:0]        shift_ctrl,
  output logic [5:0]        alu_ctrl,
  output logic [8:0]        c_enable,
  output logic [2:0]        mem_ctrl,
  output logic [3:0]        b_sel,
  output logic              n_flag,
  output logic              z_flag,
  output logic              halted
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] mpc_q, mpc_d;
  logic [WORD_W-1:0] mir_q, mir_d;
  logic              n_q, n_d;
  logic              z_q, z_d;

  logic [ADDR_W-1:0] next_mpc;
  logic              halt_req;

  mic1_next_addr u_next_addr (
    .next_address (mir_q[NEXT_HI:NEXT_LO]),
    .jmpc         (mir_q[JMPC_BIT]),
    .jamn         (mir_q[JAMN_BIT]),
    .jamz         (mir_q[JAMZ_BIT]),
    .alu_n        (alu_n),
    .alu_z        (alu_z),
    .mbr          (mbr),
    .next_mpc     (next_mpc)
  );

  // Halt only on a plain jump to HALT_ADDR; any JAM/JMPC makes 0x1FF a real target.
  assign halt_req = (mir_q[NEXT_HI:NEXT_LO] == HALT_ADDR) & ~mir_q[JMPC_BIT] &
                    ~mir_q[JAMN_BIT] & ~mir_q[JAMZ_BIT];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      mpc_q   <= '0;
      mir_q   <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      mpc_q   <= mpc_d;
      mir_q   <= mir_d;
      n_q     <= n_d;
      z_q     <= z_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mpc_d      = mpc_q;
    mir_d      = mir_q;
    n_d        = n_q;
    z_d        = z_q;
    rom_addr   = next_mpc;
    shift_ctrl = mir_q[SHIFT_HI:SHIFT_LO];
    alu_ctrl   = mir_q[ALU_HI:ALU_LO];
    c_enable   = mir_q[CEN_HI:CEN_LO];
    mem_ctrl   = mir_q[MEM_HI:MEM_LO];
    b_sel      = mir_q[BSEL_HI:BSEL_LO];
    halted     = 1'b0;

    unique case (state_q)
      StFetch: begin
        // MIR is the reset NOP here; wait_req is deliberately ignored.
        rom_addr = '0;
        mpc_d    = '0;
        mir_d    = rom_data;
        state_d  = StRun;
      end
      StRun: begin
        if (wait_req) begin
          state_d = StStall;
        end else begin
          mpc_d = next_mpc;
          mir_d = rom_data;
          n_d   = alu_n;
          z_d   = alu_z;
          // The halting instruction still completes and advances mpc to its target.
          if (halt_req) begin
            state_d = StHalt;
          end
        end
      end
      StStall: begin
        // Writes of the re-presented instruction were already committed.
        c_enable = '0;
        mem_ctrl = '0;
        if (!wait_req) begin
          state_d = StRun;
        end
      end
      StHalt: begin
        rom_addr   = mpc_q;
        shift_ctrl = '0;
        alu_ctrl   = '0;
        c_enable   = '0;
        mem_ctrl   = '0;
        b_sel      = '0;
        halted     = 1'b1;
      end
    endcase
  end

  assign mpc    = mpc_q;
  assign n_flag = n_q;
  assign z_flag = z_q;

endmodule

// File: tb/tb_mic1_sequencer.sv
module tb_mic1_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [8:0]  rom_addr;
  logic [35:0] rom_data;
  logic        alu_n, alu_z;
  logic [7:0]  mbr;
  logic        wait_req;
  logic [8:0]  mpc;
  logic [1:0]  shift_ctrl;
  logic [5:0]  alu_ctrl;
  logic [8:0]  c_enable;
  logic [2:0]  mem_ctrl;
  logic [3:0]  b_sel;
  logic        n_flag, z_flag, halted;

  logic [35:0] rom [512];
  int total = 0;
  int bad   = 0;

  assign rom_data = rom[rom_addr];

  always #5 clock = ~clock;

  mic1_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .alu_n      (alu_n),
    .alu_z      (alu_z),
    .mbr        (mbr),
    .wait_req   (wait_req),
    .mpc        (mpc),
    .shift_ctrl (shift_ctrl),
    .alu_ctrl   (alu_ctrl),
    .c_enable   (c_enable),
    .mem_ctrl   (mem_ctrl),
    .b_sel      (b_sel),
    .n_flag     (n_flag),
    .z_flag     (z_flag),
    .halted     (halted)
  );

  function automatic logic [35:0] mk(input logic [8:0] nxt, input logic jm, input logic jn,
                                     input logic jz, input logic [1:0] sh,
                                     input logic [5:0] alu, input logic [8:0] ce,
                                     input logic [2:0] mem, input logic [3:0] b);
    return {nxt, jm, jn, jz, sh, alu, ce, mem, b};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; wait_req = 1'b0; alu_n = 1'b0; alu_z = 1'b0; mbr = 8'h00;
    #2;
    total++;
    if ({mpc, shift_ctrl, alu_ctrl, c_enable, mem_ctrl, b_sel, n_flag, z_flag, halted} !== 36'h0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0", {mpc, shift_ctrl, alu_ctrl, c_enable,
                      mem_ctrl, b_sel, n_flag, z_flag, halted});
    end
    total++;
    if (rom_addr !== 9'h000) begin
      bad++; $display("FAIL reset_rom_addr got=%h exp=000", rom_addr);
    end
    reset = 1'b0;
  endtask

  // First instruction from addr 0; wait_req in FETCH must be ignored.
  task automatic test_first_fetch();
    wait_req = 1'b1;
    step();
    wait_req = 1'b0;
    total++;
    if (mpc !== 9'h000 || shift_ctrl !== 2'b10 || c_enable !== 9'h001) begin
      bad++; $display("FAIL first_instr got mpc=%h sh=%b ce=%h exp mpc=000 sh=10 ce=001",
                      mpc, shift_ctrl, c_enable);
    end
    total++;
    if (mic1_pkg::shift_apply(shift_ctrl, 32'h88888888) !== 32'h88888800) begin
      bad++; $display("FAIL shift_sll8 got=%h exp=88888800",
                      mic1_pkg::shift_apply(shift_ctrl, 32'h88888888));
    end
    total++;
    if (rom_addr !== 9'h005) begin
      bad++; $display("FAIL first_rom_addr got=%h exp=005", rom_addr);
    end
    step();
    total++;
    if (mpc !== 9'h005) begin
      bad++; $display("FAIL second_mpc got=%h exp=005", mpc);
    end
  endtask

  task automatic test_jam();
    alu_z = 1'b1; #1;
    total++;
    if (rom_addr !== 9'h110) begin bad++; $display("FAIL jamz_taken got=%h exp=110", rom_addr); end
    alu_z = 1'b0; alu_n = 1'b1; #1;
    total++;
    if (rom_addr !== 9'h010) begin bad++; $display("FAIL jamz_not got=%h exp=010", rom_addr); end
    alu_z = 1'b1;
    step();
    total++;
    if (mpc !== 9'h110 || z_flag !== 1'b1 || n_flag !== 1'b1) begin
      bad++; $display("FAIL jamz_step got mpc=%h n=%b z=%b exp 110 1 1", mpc, n_flag, z_flag);
    end
    #1;
    total++;
    if (rom_addr !== 9'h120) begin bad++; $display("FAIL jamn_taken got=%h exp=120", rom_addr); end
    alu_n = 1'b0; #1;
    total++;
    if (rom_addr !== 9'h020) begin bad++; $display("FAIL jamn_not got=%h exp=020", rom_addr); end
    alu_z = 1'b0;
    step();
    total++;
    if (mpc !== 9'h020 || n_flag !== 1'b0 || z_flag !== 1'b0) begin
      bad++; $display("FAIL jamn_step got mpc=%h n=%b z=%b exp 020 0 0", mpc, n_flag, z_flag);
    end
  endtask

  task automatic test_jmpc();
    mbr = 8'h00; #1;
    total++;
    if (rom_addr !== 9'h000) begin bad++; $display("FAIL jmpc_zero got=%h exp=000", rom_addr); end
    mbr = 8'h3C; #1;
    total++;
    if (rom_addr !== 9'h03C) begin bad++; $display("FAIL jmpc_3c got=%h exp=03c", rom_addr); end
    step();
    mbr = 8'hFF; #1;
    total++;
    if (mpc !== 9'h03C || rom_addr !== 9'h1FF) begin
      bad++; $display("FAIL jmpc_ff got mpc=%h ra=%h exp 03c 1ff", mpc, rom_addr);
    end
    step();
    total++;
    if (mpc !== 9'h1FF || halted !== 1'b0) begin
      bad++; $display("FAIL jmpc_nohalt got mpc=%h halted=%b exp 1ff 0", mpc, halted);
    end
  endtask

  task automatic test_wait();
    total++;
    if (c_enable !== 9'h080 || mem_ctrl !== 3'b010) begin
      bad++; $display("FAIL wait_pre got ce=%h mem=%b exp 080 010", c_enable, mem_ctrl);
    end
    wait_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (c_enable !== 9'h000 || mem_ctrl !== 3'b000 || mpc !== 9'h1FF || b_sel !== 4'h5 ||
          alu_ctrl !== 6'h15) begin
        bad++; $display("FAIL stall_%0d got ce=%h mem=%b mpc=%h b=%h alu=%h exp 000 000 1ff 5 15",
                        i, c_enable, mem_ctrl, mpc, b_sel, alu_ctrl);
      end
    end
    wait_req = 1'b0;
    step();
    total++;
    if (mpc !== 9'h1FF || c_enable !== 9'h080) begin
      bad++; $display("FAIL release got mpc=%h ce=%h exp 1ff 080", mpc, c_enable);
    end
    step();
    total++;
    if (mpc !== 9'h040) begin bad++; $display("FAIL release_adv got=%h exp=040", mpc); end
  endtask

  task automatic test_halt();
    total++;
    if (shift_ctrl !== 2'b01 ||
        mic1_pkg::shift_apply(shift_ctrl, 32'h88888888) !== 32'hC4444444) begin
      bad++; $display("FAIL shift_sra1 got sh=%b out=%h exp 01 c4444444", shift_ctrl,
                      mic1_pkg::shift_apply(shift_ctrl, 32'h88888888));
    end
    step();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (halted !== 1'b1 || mpc !== 9'h1FF || rom_addr !== 9'h1FF ||
          {shift_ctrl, alu_ctrl, c_enable, mem_ctrl, b_sel} !== 24'h0) begin
        bad++; $display("FAIL halt_%0d got h=%b mpc=%h ra=%h ctl=%h exp 1 1ff 1ff 0", i, halted,
                        mpc, rom_addr, {shift_ctrl, alu_ctrl, c_enable, mem_ctrl, b_sel});
      end
      alu_n = 1'($urandom); alu_z = 1'($urandom); mbr = 8'($urandom);
      step();
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (mpc !== 9'h000 || halted !== 1'b0) begin
      bad++; $display("FAIL halt_reset got mpc=%h halted=%b exp 000 0", mpc, halted);
    end
    reset = 1'b0; alu_n = 1'b0; alu_z = 1'b0; mbr = 8'h00;
  endtask

  task automatic test_reset_stall();
    rom[0] = mk(9'h001, 0, 0, 0, 2'b11, 6'h08, 9'h004, 3'b100, 4'h2);
    step();
    total++;
    if (shift_ctrl !== 2'b11 || c_enable !== 9'h004 ||
        mic1_pkg::shift_apply(shift_ctrl, 32'h88888888) !== 32'h88888888) begin
      bad++; $display("FAIL shift_bypass got sh=%b ce=%h out=%h exp 11 004 88888888", shift_ctrl,
                      c_enable, mic1_pkg::shift_apply(shift_ctrl, 32'h88888888));
    end
    wait_req = 1'b1;
    step();
    #1 reset = 1'b1;
    #1;
    total++;
    if (mpc !== 9'h000 || shift_ctrl !== 2'b00 || c_enable !== 9'h000 || halted !== 1'b0) begin
      bad++; $display("FAIL stall_reset got mpc=%h sh=%b ce=%h h=%b exp 000 00 000 0", mpc,
                      shift_ctrl, c_enable, halted);
    end
    reset = 1'b0; wait_req = 1'b0;
  endtask

  // Random program checked against an instruction-level model of the sequencer.
  task automatic test_random();
    logic [8:0]  m_mpc, tgt, e_rom;
    logic [35:0] m_mir;
    logic [23:0] e_ctl;
    logic        m_n, m_z;
    bit          m_fetch, m_stall, m_halt, plain_halt;
    for (int i = 0; i < 512; i++) rom[i] = {4'($urandom), $urandom};
    for (int i = 0; i < 8; i++) begin
      rom[$urandom_range(1, 511)] = mk(9'h1FF, 0, 0, 0, 2'($urandom), 6'($urandom),
                                       9'($urandom), 3'($urandom), 4'($urandom));
    end
    reset = 1'b1; #1 reset = 1'b0;
    m_mpc = 0; m_mir = 0; m_n = 0; m_z = 0; m_fetch = 1; m_stall = 0; m_halt = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc % 97 == 96 || (m_halt && $urandom_range(0, 3) == 0)) begin
        reset = 1'b1; #1 reset = 1'b0;
        m_mpc = 0; m_mir = 0; m_n = 0; m_z = 0; m_fetch = 1; m_stall = 0; m_halt = 0;
      end
      alu_n = 1'($urandom); alu_z = 1'($urandom); mbr = 8'($urandom);
      wait_req = ($urandom_range(0, 3) == 0);
      #1;
      tgt = m_mir[35:27] | {1'b0, (m_mir[26] ? mbr : 8'h00)} |
            {((m_mir[24] & alu_z) | (m_mir[25] & alu_n)), 8'h00};
      e_rom = m_fetch ? 9'h000 : (m_halt ? m_mpc : tgt);
      if (m_fetch || m_halt) e_ctl = 24'h0;
      else if (m_stall)      e_ctl = m_mir[23:0] & 24'hFF000F;
      else                   e_ctl = m_mir[23:0];
      total++;
      if (rom_addr !== e_rom || mpc !== m_mpc) begin
        bad++; $display("FAIL rnd_addr cyc=%0d got ra=%h mpc=%h exp ra=%h mpc=%h", cyc,
                        rom_addr, mpc, e_rom, m_mpc);
      end
      total++;
      if ({shift_ctrl, alu_ctrl, c_enable, mem_ctrl, b_sel} !== e_ctl ||
          {n_flag, z_flag, halted} !== {m_n, m_z, m_halt}) begin
        bad++; $display("FAIL rnd_ctl cyc=%0d got ctl=%h nzh=%b exp ctl=%h nzh=%b", cyc,
                        {shift_ctrl, alu_ctrl, c_enable, mem_ctrl, b_sel},
                        {n_flag, z_flag, halted}, e_ctl, {m_n, m_z, m_halt});
      end
      step();
      plain_halt = (m_mir[35:27] == 9'h1FF) && m_mir[26:24] == 3'b000;
      if (m_fetch) begin
        m_fetch = 0; m_mpc = 0; m_mir = rom[0];
      end else if (m_halt) begin
        // only reset leaves
      end else if (m_stall) begin
        if (!wait_req) m_stall = 0;
      end else if (wait_req) begin
        m_stall = 1;
      end else begin
        m_n = alu_n; m_z = alu_z; m_mpc = tgt; m_mir = rom[tgt];
        if (plain_halt) m_halt = 1;
      end
    end
    wait_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 512; i++) rom[i] = 36'h0;
    rom[9'h000] = mk(9'h005, 0, 0, 0, 2'b10, 6'h00, 9'h001, 3'b000, 4'h0);
    rom[9'h005] = mk(9'h010, 0, 0, 1, 2'b00, 6'h3C, 9'h002, 3'b000, 4'h1);
    rom[9'h110] = mk(9'h020, 0, 1, 0, 2'b00, 6'h35, 9'h000, 3'b000, 4'h2);
    rom[9'h020] = mk(9'h000, 1, 0, 0, 2'b00, 6'h14, 9'h000, 3'b001, 4'h3);
    rom[9'h03C] = mk(9'h100, 1, 0, 0, 2'b00, 6'h18, 9'h010, 3'b000, 4'h4);
    rom[9'h1FF] = mk(9'h040, 0, 0, 0, 2'b10, 6'h15, 9'h080, 3'b010, 4'h5);
    rom[9'h040] = mk(9'h1FF, 0, 0, 0, 2'b01, 6'h3C, 9'h1FF, 3'b001, 4'hA);
    test_reset();
    test_first_fetch();
    test_jam();
    test_jmpc();
    test_wait();
    test_halt();
    test_reset_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mic1_sequencer.md
# mic1_sequencer

Microprogram sequencer for the MIC-1 datapath: holds MPC and MIR, selects the next microinstruction address from NEXT_ADDRESS, JAMN/JAMZ/JMPC, the ALU N/Z flags and MBR, and drives the shifter, ALU, C-bus, B-bus and memory control fields. It sits between the external control store (combinational ROM, 512 x 36) and the datapath. It adds a wait handshake for slow memory and a halt state.

## Interface
- `ADDR_W`, default 9: microaddress width.
- `WORD_W`, default 36: microinstruction width.
- `HALT_ADDR`, default 9'h1FF: NEXT_ADDRESS value that requests halt.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `rom_addr`  out  9  control-store address, equal to next_mpc (combinational).
- `rom_data`  in  36  control-store word at `rom_addr`.
- `alu_n`, `alu_z`  in  1 each  ALU negative/zero for the current microinstruction.
- `mbr`  in  8  MBR contents for JMPC.
- `wait_req`  in  1  memory not ready; freeze sequencing.
- `mpc`  out  9  current microinstruction address.
- `shift_ctrl`  out  2  {SLL8, SRA1}; 10 = shift left 8, 01 = arithmetic shift right 1, 00/11 = bypass.
- `alu_ctrl`  out  6  {F0,F1,ENA,ENB,INVA,INC}.
- `c_enable`  out  9  C-bus register write enables.
- `mem_ctrl`  out  3  {WRITE,READ,FETCH}.
- `b_sel`  out  4  B-bus source select.
- `n_flag`, `z_flag`  out  1 each  latched N/Z of the last executed microinstruction.
- `halted`  out  1  sequencer in HALT.

## Operation
- MIR field map: [35:27] NEXT_ADDRESS, [26] JMPC, [25] JAMN, [24] JAMZ, [23:22] shift_ctrl, [21:16] alu_ctrl, [15:7] c_enable, [6:4] mem_ctrl, [3:0] b_sel.
- Next address: hi = NEXT_ADDRESS[8] | (JAMZ & alu_z) | (JAMN & alu_n). lo = NEXT_ADDRESS[7:0] | (JMPC ? mbr : 8'h00). next_mpc = {hi, lo}.
- FSM states:
  - FETCH: entered on reset. MIR is a NOP; rom_addr = 0. After one edge go to RUN with MIR = rom_data, mpc = 0.
  - RUN: each edge with wait_req = 0 does mpc <= next_mpc, MIR <= rom_data, n_flag/z_flag <= alu_n/alu_z. With wait_req = 1 go to STALL. If MIR NEXT_ADDRESS == HALT_ADDR with no JAM/JMPC, go to HALT after this instruction executes.
  - STALL: MPC, MIR and flags hold. c_enable and mem_ctrl are forced to 0; other fields stay as MIR. Returns to RUN on the first edge with wait_req = 0, with no advance on that edge.
  - HALT: all control outputs are 0 and halted = 1. rom_addr = mpc. Only reset exits.
- Outside STALL/HALT, outputs equal MIR fields directly, with no extra logic.

## Timing
- Reset (asynchronous, immediate): mpc = 0, MIR = 0, all control outputs 0, n_flag = z_flag = 0, halted = 0, state FETCH.
- Reset asserted mid-STALL or mid-HALT wins immediately.
- Latency: the first real microinstruction (addr 0) drives outputs from the 1st edge after reset deassertion.
- One microinstruction per clock in RUN.
- rom_addr has a combinational path from alu_n/alu_z/mbr within the same cycle. No flag is used a cycle late.
- wait_req is sampled at the edge. Raising it in cycle k keeps instruction k executing; its register writes were committed by the datapath at edge k. It then re-presents instruction k with writes masked until release.
- wait_req = 1 in FETCH is ignored.
- JMPC with mbr = 0 gives NEXT_ADDRESS unchanged. An OR carrying into bit 8 is impossible, since lo is 8 bits and wraps within them.

## Structure
- Shared package `mic1_pkg`: MIR field bit positions, `HALT_ADDR`, shift_ctrl encodings (SHIFT_NONE, SHIFT_SRA1, SHIFT_SLL8), and the FSM state enum.
- Sub-module `mic1_next_addr`: purely combinational next-address logic (NEXT_ADDRESS, JAM bits, N, Z, mbr → next_mpc), verified standalone.

## Test plan
- Reset then run, with ROM[0] = NEXT 0x005, shift 10, c_enable 0x001 → edge 1: mpc = 0, shift_ctrl = 10, c_enable = 0x001. Edge 2: mpc = 0x005.
- JAMZ with NEXT 0x010, alu_z = 1 → next mpc = 0x110. With alu_z = 0 → 0x010. Check the same for JAMN with alu_n.
- JMPC with NEXT 0x000, mbr = 8'h3C → next mpc = 0x03C. With NEXT 0x100 and mbr = 8'hFF → 0x1FF, not a halt because JMPC is set.
- wait_req high for 3 cycles while MIR has c_enable 0x080 and mem READ → c_enable = 0 and mem_ctrl = 0 for 3 cycles, mpc constant. After release, advances to NEXT.
- Microinstruction with NEXT 0x1FF and no jumps → halted = 1 the next cycle, all controls 0, mpc frozen. Reset asserted asynchronously → mpc = 0 and halted = 0 immediately.
- shift_ctrl = 01 with data 0x88888888 → shifter output 0xC4444444. shift_ctrl = 11 → bypass 0x88888888.
